// File: rtl/pp_seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pp_seq_multiplier                                            |
// | Description : Sequential shift-add multiplier. The WIDTH partial-product   |
// |               rows of A x B are summed ROWS_PER_CYCLE rows per clock into  |
// |               a 2*WIDTH-bit accumulator. Each transaction selects unsigned |
// |               or two's-complement operands. Operands are taken on a        |
// |               valid/ready handshake and the product is returned on one.    |
// | Ports       : clk, rst_n (async, active low), clear (sync abort)           |
// |               in_valid/in_ready/in_signed/in_a/in_b  - operand handshake   |
// |               out_valid/out_ready/out_p               - product handshake  |
// |               busy                                    - accumulating       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module pp_seq_multiplier #(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(WIDTH - ROWS_PER_CYCLE);
    localparam logic [IDX_W-1:0] C_STEP     = IDX_W'(ROWS_PER_CYCLE);
    localparam logic [IDX_W-1:0] C_TOP_ROW  = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                              r_state;
    state_t                              w_state_next;

    logic [PW-1:0]                       r_a;       // multiplicand, already extended to PW
    logic [WIDTH-1:0]                    r_b;
    logic                                r_signed;
    logic [PW-1:0]                       r_acc;
    logic [IDX_W-1:0]                    r_idx;     // first row handled this cycle

    logic                                w_accept;
    logic                                w_last;
    logic [ROWS_PER_CYCLE-1:0][PW-1:0]   w_rows;
    logic [ROWS_PER_CYCLE-1:0]           w_sub;
    logic [PW-1:0]                       w_acc_next;

    assign w_last = (r_idx == C_LAST_IDX);

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Abort overrides any transition, including an accept in IDLE.
        if (clear) begin
            w_state_next = S_IDLE;
            w_accept     = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Partial-product rows for this cycle
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < ROWS_PER_CYCLE; k++) begin : g_rows
        logic [IDX_W-1:0] w_pos;
        logic             w_bit;

        assign w_pos     = r_idx + IDX_W'(k);
        assign w_bit     = |(r_b & (WIDTH'(1) << w_pos));
        assign w_rows[k] = w_bit ? (r_a << w_pos) : '0;
        // The multiplier's sign bit carries weight -2^(WIDTH-1) in signed mode.
        assign w_sub[k]  = r_signed && (w_pos == C_TOP_ROW);
    end

    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            if (w_sub[k]) begin
                w_acc_next = w_acc_next - w_rows[k];
            end else begin
                w_acc_next = w_acc_next + w_rows[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            r_idx    <= '0;
        end else if (w_accept) begin
            r_a      <= in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};
            r_b      <= in_b;
            r_signed <= in_signed;
            r_acc    <= '0;
            r_idx    <= '0;
        end else if ((r_state == S_BUSY) && !clear) begin
            r_acc    <= w_acc_next;
            r_idx    <= r_idx + C_STEP;
        end
    end

    // Product is only presented in DONE so that reset and idle show zero.
    assign out_p = (r_state == S_DONE) ? r_acc : '0;

endmodule
`default_nettype wire

// File: tb/tb_pp_seq_multiplier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pp_seq_multiplier                                         |
// | Description : Self-checking bench. Three multipliers (ROWS_PER_CYCLE 1, 2, |
// |               4, WIDTH 8) share one stimulus stream; each is checked for   |
// |               product, latency, initiation interval and control corners.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_pp_seq_multiplier;

    localparam int W  = 8;
    localparam int NI = 3;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] p;
    } vec_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic clear     = 1'b0;
    logic in_valid  = 1'b0;
    logic in_signed = 1'b0;
    logic out_ready = 1'b1;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;

    logic [NI-1:0]  in_ready;
    logic [NI-1:0]  out_valid;
    logic [NI-1:0]  busy;
    logic [2*W-1:0] out_p [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pp_seq_multiplier #(.WIDTH(W), .ROWS_PER_CYCLE(1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready[0]), .in_signed(in_signed),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_p(out_p[0]),
        .busy(busy[0])
    );

    pp_seq_multiplier #(.WIDTH(W), .ROWS_PER_CYCLE(2)) u_r2 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready[1]), .in_signed(in_signed),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_p(out_p[1]),
        .busy(busy[1])
    );

    pp_seq_multiplier #(.WIDTH(W), .ROWS_PER_CYCLE(4)) u_r4 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready[2]), .in_signed(in_signed),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_p(out_p[2]),
        .busy(busy[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference product straight from the language's multiply operator.
    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        int sa;
        int sb;
        int prod;
        sa   = s ? int'($signed(a)) : int'(a);
        sb   = s ? int'($signed(b)) : int'(b);
        prod = sa * sb;
        return prod[2*W-1:0];
    endfunction

    // Wait (bounded) until every instance is idle.
    task automatic wait_idle(input string tag);
        for (int t = 0; t < 20 && in_ready != 3'b111; t++) @(negedge clk);
        chk({tag, " idle"}, 32'(in_ready), 32'h7);
    endtask

    // One transaction with out_ready=1: checks product and latency of each instance.
    task automatic do_txn(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp);
        int             seen [NI];
        logic [2*W-1:0] got  [NI];
        logic [NI-1:0]  ready_bad;
        wait_idle(tag);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_signed = s;
        in_a      = a;
        in_b      = b;
        @(negedge clk);
        in_valid  = 1'b0;
        in_a      = W'($urandom);
        in_b      = W'($urandom);
        in_signed = 1'($urandom);
        chk({tag, " busy"}, 32'(busy), 32'h7);
        ready_bad = '0;
        for (int j = 0; j < NI; j++) begin
            seen[j] = -1;
            got[j]  = '0;
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            for (int j = 0; j < NI; j++) begin
                if (seen[j] < 0) begin
                    if (out_valid[j]) begin
                        seen[j] = k;
                        got[j]  = out_p[j];
                    end
                    if (in_ready[j]) ready_bad[j] = 1'b1;
                end
            end
        end
        for (int j = 0; j < NI; j++) begin
            chk($sformatf("%s prod r%0d", tag, 1 << j), 32'(got[j]), 32'(exp));
            chk($sformatf("%s lat r%0d", tag, 1 << j), 32'(seen[j]), 32'(8 >> j));
        end
        chk({tag, " in_ready low"}, 32'(ready_bad), 32'h0);
    endtask

    vec_t vecs [15];

    initial begin
        int             ii   [NI];
        int             last [NI];
        logic [NI-1:0]  prev;
        logic [2*W-1:0] snap [NI];
        logic           s;
        logic [W-1:0]   a;
        logic [W-1:0]   b;

        vecs[0]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
        vecs[1]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2]  = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};
        vecs[3]  = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[4]  = '{1'b1, 8'h00, 8'h80, 16'h0000};
        vecs[5]  = '{1'b0, 8'hA5, 8'h3C, 16'h26AC};
        vecs[6]  = '{1'b1, 8'hA5, 8'h3C, 16'hEAAC};
        vecs[7]  = '{1'b0, 8'h12, 8'h34, 16'h03A8};
        vecs[8]  = '{1'b0, 8'h00, 8'h00, 16'h0000};
        vecs[9]  = '{1'b0, 8'hFF, 8'h01, 16'h00FF};
        vecs[10] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
        vecs[11] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[12] = '{1'b1, 8'h01, 8'h80, 16'hFF80};
        vecs[13] = '{1'b0, 8'h80, 8'h80, 16'h4000};
        vecs[14] = '{1'b0, 8'h80, 8'h02, 16'h0100};

        // Reset values while rst_n is held low
        #1;
        chk("rst in_ready", 32'(in_ready), 32'h7);
        chk("rst out_valid", 32'(out_valid), 32'h0);
        chk("rst busy", 32'(busy), 32'h0);
        for (int j = 0; j < NI; j++) chk($sformatf("rst out_p r%0d", 1 << j), 32'(out_p[j]), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Back-to-back: in_valid held high, measure initiation interval per instance
        wait_idle("b2b");
        in_valid  = 1'b1;
        in_signed = 1'b0;
        in_a      = 8'hFF;
        in_b      = 8'hFF;
        prev      = busy;
        for (int j = 0; j < NI; j++) begin
            ii[j]   = -1;
            last[j] = -1;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int j = 0; j < NI; j++) begin
                if (busy[j] && !prev[j]) begin
                    if (last[j] >= 0 && ii[j] < 0) ii[j] = c - last[j];
                    last[j] = c;
                end
                if (out_valid[j]) chk($sformatf("b2b prod r%0d", 1 << j), 32'(out_p[j]), 32'hFE01);
            end
            prev = busy;
        end
        in_valid = 1'b0;
        for (int j = 0; j < NI; j++) chk($sformatf("b2b ii r%0d", 1 << j), 32'(ii[j]), 32'((8 >> j) + 2));

        // Backpressure: hold out_ready low for 5 cycles once all products are ready
        wait_idle("bp");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_signed = 1'b0;
        in_a      = 8'hA5;
        in_b      = 8'h3C;
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 12 && out_valid != 3'b111; t++) @(negedge clk);
        chk("bp all valid", 32'(out_valid), 32'h7);
        for (int j = 0; j < NI; j++) snap[j] = out_p[j];
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            chk("bp out_valid", 32'(out_valid), 32'h7);
            chk("bp in_ready", 32'(in_ready), 32'h0);
            chk("bp busy", 32'(busy), 32'h0);
            for (int j = 0; j < NI; j++) begin
                chk($sformatf("bp stable r%0d", 1 << j), 32'(out_p[j]), 32'(snap[j]));
                chk($sformatf("bp prod r%0d", 1 << j), 32'(out_p[j]), 32'h26AC);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release in_ready", 32'(in_ready), 32'h7);
        chk("bp release out_valid", 32'(out_valid), 32'h0);

        // Asynchronous reset in the middle of BUSY (r1 instance at row 3)
        wait_idle("arst");
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("arst pre busy r1", 32'(busy[0]), 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst out_valid", 32'(out_valid), 32'h0);
        chk("arst busy", 32'(busy), 32'h0);
        chk("arst in_ready", 32'(in_ready), 32'h7);
        @(negedge clk);
        rst_n = 1'b1;
        do_txn("post-arst", 1'b0, 8'h12, 8'h34, 16'h03A8);

        // clear during BUSY
        wait_idle("clr busy");
        in_valid = 1'b1;
        in_a     = 8'h55;
        in_b     = 8'h66;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr busy pre", 32'(busy), 32'h7);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr busy busy", 32'(busy), 32'h0);
        chk("clr busy out_valid", 32'(out_valid), 32'h0);
        chk("clr busy in_ready", 32'(in_ready), 32'h7);

        // clear during DONE
        out_ready = 1'b0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int t = 0; t < 12 && out_valid != 3'b111; t++) @(negedge clk);
        chk("clr done pre", 32'(out_valid), 32'h7);
        clear = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        out_ready = 1'b1;
        chk("clr done out_valid", 32'(out_valid), 32'h0);
        chk("clr done in_ready", 32'(in_ready), 32'h7);
        chk("clr done busy", 32'(busy), 32'h0);

        // clear together with in_valid in IDLE: nothing accepted
        clear    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("clr idle busy", 32'(busy), 32'h0);
        chk("clr idle in_ready", 32'(in_ready), 32'h7);
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr idle after", 32'(busy), 32'h0);

        // Random sweep, both modes
        for (int i = 0; i < 2000; i++) begin
            s = 1'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            do_txn($sformatf("rnd%0d s%0d %02h*%02h", i, s, a, b), s, a, b, ref_mul(s, a, b));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pp_seq_multiplier.md
# pp_seq_multiplier

Parametrised sequential shift-add multiplier: generates the WIDTH partial-product rows of A×B and accumulates ROWS_PER_CYCLE rows per clock into a 2·WIDTH-bit product. It supports unsigned and two's-complement operands, selected per transaction. It replaces the fixed 8×8 combinational partial-product stage in the datapath wherever area matters more than latency. Operands enter and results leave over valid/ready handshakes.

## Interface
- WIDTH, 8: operand width; even, 4..32.
- ROWS_PER_CYCLE, 1: partial-product rows accumulated per cycle; must divide WIDTH (1, 2, 4 legal for WIDTH=8).
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; returns the block to IDLE and drops any result in flight.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_p  out  2·WIDTH  product.
- busy  out  1  high in BUSY state.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch the operands and in_signed, zero the accumulator, set row index to 0, go to BUSY.
- BUSY: each cycle add rows i..i+ROWS_PER_CYCLE-1, then advance i by ROWS_PER_CYCLE.
  - Row i = (A extended to 2·WIDTH) AND {B[i]}, shifted left by i.
  - A is sign-extended when signed and zero-extended when unsigned.
  - Signed mode: row WIDTH-1 is subtracted instead of added, giving the exact two's-complement product.
  - Accumulator arithmetic is modulo 2^(2·WIDTH). The true product always fits, so no overflow can occur.
  - After the last row, go to DONE.
- DONE:
  - out_valid=1 and out_p = accumulator.
  - out_p is held stable while out_ready=0.
  - On out_ready, go to IDLE.
- clear takes priority over every transition. Next state is IDLE, and out_valid and busy fall on that edge. The accumulator is not required to be zeroed.
- in_ready is high only in IDLE, so operands are never accepted in BUSY or DONE.
- in_valid while in_ready=0 is ignored; no operand is dropped silently, because the producer must hold it.
- No handshake across states in one cycle: a DONE→IDLE edge cannot also accept new operands.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, out_p=0.
- Let N = WIDTH/ROWS_PER_CYCLE.
- Latency:
  - Accept edge E: state becomes BUSY.
  - Edges E+1..E+N: accumulation.
  - out_valid is first seen high after edge E+N.
- Minimum initiation interval is N+2 cycles: accept, N busy cycles, one DONE cycle with out_ready=1, then one IDLE cycle to accept.
- Reset asserted mid-operation: all outputs return to reset values immediately, independent of clk. The first accept is possible on the first rising edge after rst_n deasserts.
- clear and in_valid together in IDLE: clear wins, nothing is accepted.
- clear and out_ready together in DONE: IDLE; the result is treated as consumed, with no double count.
- Inputs in_a, in_b and in_signed are don't-care outside the accept cycle.

## Test plan
- WIDTH=8, ROWS_PER_CYCLE=1, unsigned, A=0xFF, B=0xFF, out_ready=1 → out_p=0xFE01 with out_valid high 8 edges after accept. in_ready=0 throughout; back-to-back initiation interval is 10 cycles.
- Signed, WIDTH=8:
  - 0x80×0x80 → 0x4000.
  - 0xFF×0x01 → 0xFFFF.
  - 0x80×0x7F → 0xC080.
  - 0x00×0x80 → 0x0000.
- ROWS_PER_CYCLE=2 and 4 with WIDTH=8, unsigned 0xA5×0x3C → 0x26AC. Latency is 4 and 2 edges respectively; a 2000-vector random sweep, both modes, must match the reference product.
- Backpressure: product ready, out_ready=0 for 5 cycles → out_valid and out_p stable, in_ready=0, busy=0. out_ready=1 → next edge IDLE, in_ready=1.
- Async reset mid-BUSY (rst_n low between edges at row 3) → out_valid=0, busy=0 and in_ready=1 without a clock edge. A new 0x12×0x34 afterwards → 0x03A8.
- clear in BUSY and in DONE → IDLE next edge with out_valid=0. clear with in_valid in IDLE → no accept, busy stays 0.
